rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter plus registered output stage that shares one output channel among N requesters.
- Each requester offers a DW-bit word with valid/ready; the block selects one, drives the data through a one-hot AND-OR mux and presents it on a single valid/ready output.
- Sits in front of any shared sink fed by the mux2x1/4x1 AND-OR datapaths; it is the sequencer that decides which input the mux selects and when.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 2, data width per requester.
- IW, $clog2(N), width of grant_id (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester valid.
- req_data  in  N*DW  packed data; requester i occupies bits [i*DW +: DW].
- req_ready  out  N  one-hot accept pulse; the word of requester i is consumed on a cycle where req_valid[i] && req_ready[i].
- out_valid  out  1  output word valid.
- out_data  out  DW  registered selected word.
- out_ready  in  1  sink accept.
- grant_id  out  IW  index of the requester whose word is in out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, grant_id=0, req_ready=0.
  - Round-robin pointer ptr=0; state=EMPTY.
  - A held output word is discarded and not replayed.
- State EMPTY (out_valid=0):
  - If no req_valid is high, remain in EMPTY.
  - Otherwise the winner g is the first i with req_valid[i]=1, scanning ptr, ptr+1, … wrapping mod N.
  - Same cycle: req_ready is one-hot with bit g set (combinational from req_valid and ptr).
  - Next edge: out_data<=req_data[g], grant_id<=g, out_valid<=1, ptr<=(g+1) mod N, state->FULL.
- State FULL (out_valid=1):
  - out_data and grant_id are held stable while out_ready=0; req_ready=0.
  - On out_ready=1 (handshake), re-arbitrate in the same cycle using the current ptr (already g+1).
  - If a winner w exists: req_ready[w]=1, and next edge loads w, ptr<=(w+1) mod N, state stays FULL. Back-to-back throughput is 1 word per cycle.
  - If no winner exists: next edge out_valid<=0, state->EMPTY. out_data and grant_id keep their last values.
- Latency: 1 cycle from accepted request to out_valid.
- Data selection:
  - Mask each req_data slice with its replicated one-hot grant bit and OR the results. No priority chain on data.
  - The one-hot grant guarantees a single non-zero term.
- Fairness:
  - A requester holding req_valid continuously waits at most N-1 grants.
  - The pointer advances only on an actual grant, never on idle cycles.
- Requester rules:
  - Deasserting req_valid without a handshake is allowed (withdrawal).
  - req_data is sampled only on the handshake cycle.
- out_ready while out_valid=0: ignored.
- req_ready is never asserted for a requester whose req_valid=0; at most one bit of req_ready is set.
- Pointer wrap: after granting N-1, ptr=0.
- rst has priority over every handshake in the same cycle. A req handshake in a reset cycle is not consumed (req_ready=0 during rst).
- Assertions for verification:
  - $onehot0(req_ready).
  - out_data/grant_id stable while out_valid && !out_ready.
  - No req_ready while out_valid && !out_ready.

Test Plan:
- Single requester: N=4, DW=2, only req_valid[2]=1, data=3, out_ready=1 → req_ready=4'b0100 in cycle 0; cycle 1 out_valid=1, out_data=3, grant_id=2; ptr=3.
- All requesting, data {3,2,1,0} for i=3..0, out_ready=1 constantly → grant_id sequence 0,1,2,3,0 on consecutive cycles; out_data 0,1,2,3,0; no bubbles.
- Backpressure: req_valid[1]=1 (data 2), out_ready=0 for 5 cycles → out_valid=1 with out_data=2 and grant_id=1 held; req_ready=0 throughout; after out_ready=1 one cycle → out_valid=0 next cycle if no other req.
- Pointer skip/wrap: ptr=3, req_valid=4'b0011 → grant 0, then 1; with req_valid[3] later raised alongside 0, grant 3 first (ptr=2 after granting 1).
- Withdrawal: req_valid[2] drops while out_valid held with grant 0 → at handshake the arbiter picks the next valid requester, never 2; req_ready[2] never asserted.
- Reset mid-operation: out_valid=1 with grant_id=3, assert rst for one cycle with out_ready=1 and req_valid=4'hF → after reset out_valid=0, grant_id=0, req_ready=0 during rst; the next grant is requester 0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a one-hot AND-OR data mux and a registered
// valid/ready output stage that shares one sink among N requesters.
module rr_mux_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_valid,
    input  logic [N*DW-1:0]         req_data,
    output logic [N-1:0]            req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    grant_id
);

    localparam int unsigned IW = $clog2(N);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [DW-1:0] data_q, data_d;

    logic          arb_en_c;
    logic          found_c;
    logic [IW:0]   idx_c;
    logic [IW-1:0] win_c;
    logic [N-1:0]  grant_c;
    logic [DW-1:0] mux_c;

    // First valid requester scanning ptr, ptr+1, ... modulo N
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_c = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx_c >= (IW+1)'(N)) begin
                idx_c = idx_c - (IW+1)'(N);
            end
            if (!found_c && req_valid[idx_c[IW-1:0]]) begin
                found_c = 1'b1;
                win_c   = idx_c[IW-1:0];
            end
        end
    end

    // Arbitration is open when the output slot is empty or draining this cycle
    assign arb_en_c = !rst && ((state_q == S_EMPTY) || out_ready);

    always_comb begin
        grant_c = '0;
        if (arb_en_c && found_c) begin
            grant_c[win_c] = 1'b1;
        end
    end

    assign req_ready = grant_c;

    always_comb begin
        mux_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mux_c = mux_c | (req_data[i*DW +: DW] & {DW{grant_c[i]}});
        end
    end

    // Next-state: load on grant, drop to EMPTY when the sink drains with no winner
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        case (state_q)
            S_EMPTY: begin
                if (|grant_c) begin
                    state_d = S_FULL;
                    data_d  = mux_c;
                    gid_d   = win_c;
                    ptr_d   = (win_c == IW'(N-1)) ? '0 : win_c + IW'(1);
                end
            end
            S_FULL: begin
                if (out_ready && !rst) begin
                    if (|grant_c) begin
                        data_d = mux_c;
                        gid_d  = win_c;
                        ptr_d  = (win_c == IW'(N-1)) ? '0 : win_c + IW'(1);
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle against a reference model.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    grant_id;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model state
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_gid   = 0;
    int m_ptr   = 0;
    int wait_cnt [N];

    rr_mux_arbiter #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Winner index by the round-robin rule, or -1 if nothing may be granted
    function automatic int model_winner();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int w;
        w = model_winner();
        return (w < 0) ? 0 : (1 << w);
    endfunction

    // Compare DUT against model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("rnd_req_ready", int'(req_ready), model_ready());
            check("rnd_out_valid", int'(out_valid), int'(m_valid));
            check("rnd_out_data",  int'(out_data),  m_data);
            check("rnd_grant_id",  int'(grant_id),  m_gid);
        end
    end

    // Model update on the clock edge, plus starvation bound
    always @(posedge clk) begin
        int w;
        w = model_winner();
        for (int i = 0; i < N; i++) begin
            if (rst || !req_valid[i] || w == i) begin
                wait_cnt[i] = 0;
            end else if (w >= 0) begin
                wait_cnt[i] = wait_cnt[i] + 1;
                if (chk_en) check("fairness_wait", (wait_cnt[i] <= N-1) ? 1 : 0, 1);
            end
        end
        if (rst) begin
            m_valid = 1'b0; m_data = 0; m_gid = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = int'((req_data >> (w*DW)) & ((1 << DW) - 1));
            m_gid   = w;
            m_ptr   = (w + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [7:0] d, input logic o, input logic r);
        @(posedge clk);
        #1;
        req_valid = v; req_data = d; out_ready = o; rst = r;
        #2;
    endtask

    initial begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // reset
        cyc(4'h0, 8'h00, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(4'h0, 8'h00, 1'b0, 1'b1);

        // single requester 2, data 3
        cyc(4'b0100, 8'h30, 1'b1, 1'b0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_grant_id",  int'(grant_id), 0);
        check("reset_out_data",  int'(out_data), 0);
        check("single_ready",    int'(req_ready), 4);
        cyc(4'b0000, 8'h00, 1'b1, 1'b0);
        check("single_valid", int'(out_valid), 1);
        check("single_data",  int'(out_data), 3);
        check("single_gid",   int'(grant_id), 2);
        // pointer now 3: wrap to 0, then 1, then 3 ahead of 0
        cyc(4'b0011, 8'hE4, 1'b1, 1'b0);
        check("drain_empty",  int'(out_valid), 0);
        check("drain_gid",    int'(grant_id), 2);
        check("wrap_ready0",  int'(req_ready), 1);
        cyc(4'b0011, 8'hE4, 1'b1, 1'b0);
        check("wrap_gid0",    int'(grant_id), 0);
        check("wrap_ready1",  int'(req_ready), 2);
        cyc(4'b1001, 8'hE4, 1'b1, 1'b0);
        check("wrap_gid1",    int'(grant_id), 1);
        check("skip_ready3",  int'(req_ready), 8);
        cyc(4'b0000, 8'hE4, 1'b1, 1'b0);
        check("skip_gid3",    int'(grant_id), 3);
        check("skip_data3",   int'(out_data), 3);

        // all requesting, back-to-back from ptr 0
        cyc(4'h0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'hF, 8'hE4, 1'b1, 1'b0);
            check("b2b_ready", int'(req_ready), 1 << (k % 4));
            if (k >= 1) begin
                check("b2b_valid", int'(out_valid), 1);
                check("b2b_gid",   int'(grant_id), (k - 1) % 4);
                check("b2b_data",  int'(out_data), (k - 1) % 4);
            end
        end
        cyc(4'h0, 8'hE4, 1'b1, 1'b0);
        check("b2b_last_gid", int'(grant_id), 0);
        cyc(4'h0, 8'hE4, 1'b0, 1'b0);
        check("b2b_empty", int'(out_valid), 0);

        // backpressure, ptr is 1
        cyc(4'b0010, 8'h08, 1'b0, 1'b0);
        check("bp_accept", int'(req_ready), 2);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0010, 8'h08, 1'b0, 1'b0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_data",  int'(out_data), 2);
            check("bp_gid",   int'(grant_id), 1);
            check("bp_ready", int'(req_ready), 0);
        end
        cyc(4'b0000, 8'h08, 1'b1, 1'b0);
        check("bp_release_ready", int'(req_ready), 0);
        cyc(4'b0000, 8'h08, 1'b0, 1'b0);
        check("bp_empty", int'(out_valid), 0);

        // withdrawal of requester 2 while grant 0 is held
        cyc(4'h0, 8'h00, 1'b0, 1'b1);
        cyc(4'b0101, 8'hE4, 1'b0, 1'b0);
        check("wd_ready0", int'(req_ready), 1);
        cyc(4'b0101, 8'hE4, 1'b0, 1'b0);
        check("wd_hold_gid",   int'(grant_id), 0);
        check("wd_hold_ready", int'(req_ready), 0);
        cyc(4'b1001, 8'hE4, 1'b1, 1'b0);
        check("wd_ready3", int'(req_ready), 8);
        cyc(4'b1111, 8'hE4, 1'b0, 1'b0);
        check("wd_gid3",  int'(grant_id), 3);
        check("wd_data3", int'(out_data), 3);

        // reset mid-operation with handshakes offered
        cyc(4'hF, 8'hE4, 1'b1, 1'b1);
        check("rst_ready", int'(req_ready), 0);
        cyc(4'hF, 8'hE4, 1'b1, 1'b0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_gid",   int'(grant_id), 0);
        check("rst_next_ready", int'(req_ready), 1);
        cyc(4'h0, 8'hE4, 1'b1, 1'b0);
        check("rst_next_gid",   int'(grant_id), 0);
        check("rst_next_valid", int'(out_valid), 1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 63) == 0));
        end
        cyc(4'h0, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        chk_en = 1'b0;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
